// File: rtl/armleo_cpu_tlb.sv
// Direct-mapped TLB for the ArmleoCPU Sv32-style MMU.
// Maps a 20-bit virtual page number to a 22-bit physical page number plus an
// 8-bit access tag. A lookup result is registered and appears one cycle after
// resolve. When translation is disabled the address passes straight through.
module armleo_cpu_tlb #(
  parameter int ENTRIES_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        invalidate,
  input  logic        resolve,
  input  logic        write,
  input  logic [19:0] virtual_address,
  input  logic [7:0]  accesstag_w,
  input  logic [21:0] phys_w,
  output logic        done,
  output logic        miss,
  output logic [7:0]  accesstag_r,
  output logic [21:0] phys_r
);

  localparam int ENTRIES = 1 << ENTRIES_W;
  localparam int TAG_W   = 20 - ENTRIES_W;

  // Valid bits live in flops so the whole TLB can be flushed in one cycle;
  // the payload lives in plain arrays that never need clearing.
  logic [ENTRIES-1:0] valid_reg;
  logic [TAG_W-1:0]   tag_mem       [ENTRIES];
  logic [7:0]         accesstag_mem [ENTRIES];
  logic [21:0]        phys_mem      [ENTRIES];

  logic [ENTRIES_W-1:0] idx;
  logic [TAG_W-1:0]     vtag;
  logic                 hit_next;

  assign idx  = virtual_address[ENTRIES_W-1:0];
  assign vtag = virtual_address[19:ENTRIES_W];

  // Per-entry valid bit: flush beats fill, so a write in the same cycle as an
  // invalidate leaves its entry invalid.
  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_valid
      localparam logic [ENTRIES_W-1:0] ENTRY_IDX = ENTRIES_W'(gi);
      // Valid flop for this entry.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg[gi] <= 1'b0;
        end else if (invalidate) begin
          valid_reg[gi] <= 1'b0;
        end else if (write && (idx == ENTRY_IDX)) begin
          valid_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  // Payload fill from the page-table walker; overwrites any previous mapping.
  always_ff @(posedge clk) begin
    if (write) begin
      tag_mem[idx]       <= vtag;
      accesstag_mem[idx] <= accesstag_w;
      phys_mem[idx]      <= phys_w;
    end
  end

  // Hit detection against the pre-edge array contents.
  always_comb begin
    hit_next = 1'b0;
    if (valid_reg[idx] && (tag_mem[idx] == vtag)) begin
      hit_next = 1'b1;
    end
  end

  // Registered lookup result; outputs hold between resolves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done        <= 1'b0;
      miss        <= 1'b0;
      accesstag_r <= 8'h00;
      phys_r      <= 22'h0;
    end else begin
      done <= resolve;
      if (resolve) begin
        if (!enable) begin
          miss        <= 1'b0;
          accesstag_r <= 8'h00;
          phys_r      <= {2'b00, virtual_address};
        end else if (hit_next) begin
          miss        <= 1'b0;
          accesstag_r <= accesstag_mem[idx];
          phys_r      <= phys_mem[idx];
        end else begin
          miss        <= 1'b1;
          accesstag_r <= 8'h00;
          phys_r      <= 22'h0;
        end
      end
    end
  end

endmodule

// File: tb/tb_armleo_cpu_tlb.sv
// Directed testbench for armleo_cpu_tlb.
module tb_armleo_cpu_tlb;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        invalidate;
  logic        resolve;
  logic        write;
  logic [19:0] virtual_address;
  logic [7:0]  accesstag_w;
  logic [21:0] phys_w;
  logic        done;
  logic        miss;
  logic [7:0]  accesstag_r;
  logic [21:0] phys_r;

  int errors = 0;
  int checks = 0;

  armleo_cpu_tlb #(.ENTRIES_W(6)) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .invalidate      (invalidate),
    .resolve         (resolve),
    .write           (write),
    .virtual_address (virtual_address),
    .accesstag_w     (accesstag_w),
    .phys_w          (phys_w),
    .done            (done),
    .miss            (miss),
    .accesstag_r     (accesstag_r),
    .phys_r          (phys_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic d, input logic m,
                           input logic [21:0] p, input logic [7:0] a);
    check({tag, ".done"}, 32'(done), 32'(d));
    check({tag, ".miss"}, 32'(miss), 32'(m));
    check({tag, ".phys"}, 32'(phys_r), 32'(p));
    check({tag, ".atag"}, 32'(accesstag_r), 32'(a));
    $display("txn %-14s va=%05h done=%0b miss=%0b phys=%06h atag=%02h",
             tag, virtual_address, done, miss, phys_r, accesstag_r);
  endtask

  task automatic do_write(input logic [19:0] va, input logic [21:0] p, input logic [7:0] a);
    write = 1'b1; virtual_address = va; phys_w = p; accesstag_w = a;
    tick();
    write = 1'b0;
  endtask

  task automatic do_resolve(input logic en, input logic [19:0] va);
    enable = en; virtual_address = va; resolve = 1'b1;
    tick();
    resolve = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; invalidate = 1'b0; resolve = 1'b0; write = 1'b0;
    virtual_address = 20'h0; accesstag_w = 8'h0; phys_w = 22'h0;
    #1;
    check_res("reset", 1'b0, 1'b0, 22'h0, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Bypass: identity mapping, array not consulted.
    do_resolve(1'b0, 20'h00000);
    check_res("bypass0", 1'b1, 1'b0, 22'h000000, 8'h00);
    do_resolve(1'b0, 20'hFEDCB);
    check_res("bypass1", 1'b1, 1'b0, 22'h0FEDCB, 8'h00);
    tick();
    check_res("idle_hold", 1'b0, 1'b0, 22'h0FEDCB, 8'h00);

    // Empty TLB misses.
    do_resolve(1'b1, 20'h00000);
    check_res("empty_miss", 1'b1, 1'b1, 22'h0, 8'h00);

    // Fill three entries and read them back.
    do_write(20'h20000, 22'h010000, 8'hB1);
    do_write(20'h20001, 22'h010001, 8'hB3);
    do_write(20'h20002, 22'h010002, 8'hB5);
    do_resolve(1'b1, 20'h20000);
    check_res("hit0", 1'b1, 1'b0, 22'h010000, 8'hB1);
    do_resolve(1'b1, 20'h20001);
    check_res("hit1", 1'b1, 1'b0, 22'h010001, 8'hB3);
    do_resolve(1'b1, 20'h20002);
    check_res("hit2", 1'b1, 1'b0, 22'h010002, 8'hB5);
    // Enable off on a populated entry still bypasses.
    do_resolve(1'b0, 20'h20002);
    check_res("bypass_pop", 1'b1, 1'b0, 22'h020002, 8'h00);

    // Conflicting tag replaces index 0.
    do_write(20'h20040, 22'h0ABCDE, 8'h5A);
    // Back-to-back resolves: done on consecutive cycles.
    enable = 1'b1; resolve = 1'b1; virtual_address = 20'h20000;
    tick();
    check_res("evicted", 1'b1, 1'b1, 22'h0, 8'h00);
    virtual_address = 20'h20040;
    tick();
    check_res("replaced", 1'b1, 1'b0, 22'h0ABCDE, 8'h5A);
    virtual_address = 20'h20001;
    tick();
    check_res("b2b_hit1", 1'b1, 1'b0, 22'h010001, 8'hB3);
    resolve = 1'b0;
    tick();
    check_res("done_drop", 1'b0, 1'b0, 22'h010001, 8'hB3);

    // Invalidate flushes everything.
    invalidate = 1'b1;
    tick();
    invalidate = 1'b0;
    do_resolve(1'b1, 20'h20002);
    check_res("inv_miss", 1'b1, 1'b1, 22'h0, 8'h00);

    // Resolve with a write to the same entry returns the old data.
    do_write(20'h20003, 22'h111111, 8'h11);
    write = 1'b1; phys_w = 22'h222222; accesstag_w = 8'h22;
    do_resolve(1'b1, 20'h20003);
    write = 1'b0;
    check_res("rd_during_wr", 1'b1, 1'b0, 22'h111111, 8'h11);
    do_resolve(1'b1, 20'h20003);
    check_res("after_wr", 1'b1, 1'b0, 22'h222222, 8'h22);

    // Invalidate and write together: invalidate wins.
    invalidate = 1'b1;
    do_write(20'h20005, 22'h333333, 8'h33);
    invalidate = 1'b0;
    do_resolve(1'b1, 20'h20005);
    check_res("inv_wr_miss", 1'b1, 1'b1, 22'h0, 8'h00);

    // Resolve during invalidate sees the pre-flush contents.
    do_write(20'h20006, 22'h044444, 8'h44);
    invalidate = 1'b1;
    do_resolve(1'b1, 20'h20006);
    invalidate = 1'b0;
    check_res("rd_during_inv", 1'b1, 1'b0, 22'h044444, 8'h44);
    do_resolve(1'b1, 20'h20006);
    check_res("post_inv", 1'b1, 1'b1, 22'h0, 8'h00);

    // Reset mid-lookup forces outputs low immediately and flushes the TLB.
    do_write(20'h20007, 22'h055555, 8'h55);
    do_resolve(1'b1, 20'h20007);
    check_res("pre_rst_hit", 1'b1, 1'b0, 22'h055555, 8'h55);
    #2 rst = 1'b1;
    #1;
    check_res("async_rst", 1'b0, 1'b0, 22'h0, 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    do_resolve(1'b1, 20'h20007);
    check_res("rst_flushed", 1'b1, 1'b1, 22'h0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
